// File: rtl/bp_pkg.sv
// Shared types and helpers for the gshare branch direction predictor.
// Latency: pure combinational helpers, no state.
// Backpressure: none; callers decide when results are consumed.
package bp_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Helpers operate at a fixed maximum width; callers cast to their own widths.
    localparam int MAX_CTR_W = 4;
    localparam int MAX_IDX_W = 16;

    localparam logic [MAX_CTR_W-1:0] CTR_ONE = MAX_CTR_W'(1);

    // Saturating counter step for a counter of ctr_w bits held in the low bits of ctr.
    function automatic logic [MAX_CTR_W-1:0] sat_update(
        input logic [MAX_CTR_W-1:0] ctr,
        input logic                 taken,
        input int                   ctr_w
    );
        logic [MAX_CTR_W-1:0] top;
        top = MAX_CTR_W'((5'd1 << ctr_w) - 5'd1);
        if (taken) begin
            return (ctr == top) ? ctr : ctr + CTR_ONE;
        end
        return (ctr == '0) ? ctr : ctr - CTR_ONE;
    endfunction

    // gshare index: PC bits XOR history, history aligned to the low bits.
    function automatic logic [MAX_IDX_W-1:0] gshare_idx(
        input logic [MAX_IDX_W-1:0] pc,
        input logic [MAX_IDX_W-1:0] ghr
    );
        return pc ^ ghr;
    endfunction

endpackage

// File: rtl/gshare_pht.sv
// gshare direction predictor: GHR-hashed table of saturating counters, with history repair and init sweep.
// Latency: lookup is combinational in IF; counter/GHR updates are visible to IF the cycle after they are applied.
// Backpressure: none; lookup and update are accepted every cycle, and all inputs are ignored during the init sweep.
module gshare_pht
    import bp_pkg::*;
#(
    parameter int INDEX_W  = 10,
    parameter int GHR_W    = 8,
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] pc_idxF,
    input  logic               predF,
    output logic               pht_takenF,
    output logic [GHR_W-1:0]   ghr_snapF,
    input  logic               BranchE,
    input  logic               br_actualE,
    input  logic               mispredE,
    input  logic [INDEX_W-1:0] pc_idxE,
    input  logic [GHR_W-1:0]   ghr_snapE,
    output logic               init_done
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [CTR_W-1:0]   pht_mem [DEPTH];
    state_t             state;
    logic [INDEX_W-1:0] ptr;
    logic [GHR_W-1:0]   ghr;

    logic [INDEX_W-1:0] idx_f;
    logic [INDEX_W-1:0] idx_e;
    logic [CTR_W-1:0]   rd_ctr_f;
    logic [CTR_W-1:0]   rd_ctr_e;
    logic [CTR_W-1:0]   upd_ctr;
    logic [GHR_W-1:0]   ghr_shift;
    logic [GHR_W-1:0]   ghr_recov;

    logic               wr_en;
    logic [INDEX_W-1:0] wr_addr;
    logic [CTR_W-1:0]   wr_data;

    // IF hashes with the live GHR, EX with the snapshot that travelled with the branch.
    assign idx_f = INDEX_W'(gshare_idx(MAX_IDX_W'(pc_idxF), MAX_IDX_W'(ghr)));
    assign idx_e = INDEX_W'(gshare_idx(MAX_IDX_W'(pc_idxE), MAX_IDX_W'(ghr_snapE)));

    // Async read: a same-cycle EX write is not bypassed, so IF sees the old counter.
    assign rd_ctr_f = pht_mem[idx_f];
    assign rd_ctr_e = pht_mem[idx_e];
    assign upd_ctr  = CTR_W'(sat_update(MAX_CTR_W'(rd_ctr_e), br_actualE, CTR_W));

    // Outputs are held quiet until the table holds defined values.
    assign pht_takenF = (state == RUN) && rd_ctr_f[CTR_W-1];
    assign ghr_snapF  = (state == RUN) ? ghr : '0;
    assign init_done  = (state == RUN);

    // A 1-bit history has no older bits to keep.
    generate
        if (GHR_W == 1) begin : g_ghr_one
            assign ghr_shift = pht_takenF;
            assign ghr_recov = br_actualE;
        end else begin : g_ghr_multi
            assign ghr_shift = {ghr[GHR_W-2:0], pht_takenF};
            assign ghr_recov = {ghr_snapE[GHR_W-2:0], br_actualE};
        end
    endgenerate

    // Single write port: the sweep owns it in INIT, EX updates own it in RUN.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = idx_e;
        wr_data = upd_ctr;
        if (!reset) begin
            if (state == INIT) begin
                wr_en   = 1'b1;
                wr_addr = ptr;
                wr_data = CTR_W'(INIT_CTR);
            end else begin
                wr_en   = BranchE;
            end
        end
    end

    // Counter array write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pht_mem[wr_addr] <= wr_data;
        end
    end

    // Control FSM: sweep pointer in INIT, speculative history and recovery in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
            ptr   <= '0;
            ghr   <= '0;
        end else begin
            case (state)
                INIT: begin
                    ptr <= ptr + 1'b1;
                    if (&ptr) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Recovery wins: the IF instruction this cycle is being flushed.
                    if (BranchE && mispredE) begin
                        ghr <= ghr_recov;
                    end else if (predF && !mispredE) begin
                        ghr <= ghr_shift;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_pht.sv
module tb_gshare_pht;

    logic       clk;
    logic       reset;
    logic [9:0] pc_idxF;
    logic       predF;
    logic       BranchE;
    logic       br_actualE;
    logic       mispredE;
    logic [9:0] pc_idxE;
    logic [7:0] ghr_snapE;

    logic       a_taken;
    logic [7:0] a_snap;
    logic       a_done;
    logic       b_taken;
    logic [5:0] b_snap;
    logic       b_done;

    int total = 0;
    int bad   = 0;

    gshare_pht #(.INDEX_W(10), .GHR_W(8), .CTR_W(2), .INIT_CTR(1)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .pc_idxF    (pc_idxF),
        .predF      (predF),
        .pht_takenF (a_taken),
        .ghr_snapF  (a_snap),
        .BranchE    (BranchE),
        .br_actualE (br_actualE),
        .mispredE   (mispredE),
        .pc_idxE    (pc_idxE),
        .ghr_snapE  (ghr_snapE),
        .init_done  (a_done)
    );

    gshare_pht #(.INDEX_W(6), .GHR_W(6), .CTR_W(3), .INIT_CTR(3)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .pc_idxF    (pc_idxF[5:0]),
        .predF      (predF),
        .pht_takenF (b_taken),
        .ghr_snapF  (b_snap),
        .BranchE    (BranchE),
        .br_actualE (br_actualE),
        .mispredE   (mispredE),
        .pc_idxE    (pc_idxE[5:0]),
        .ghr_snapE  (ghr_snapE[5:0]),
        .init_done  (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] pc_f;
        logic       pred_f;
        logic       br;
        logic       act;
        logic       misp;
        logic [9:0] pc_e;
        logic [7:0] snap_e;
        logic       exp_taken;
        logic [7:0] exp_snap;
    } vec_t;

    vec_t va[$];
    vec_t vb[$];

    function automatic vec_t mk(logic [9:0] pf, logic p, logic b, logic a, logic m,
                                logic [9:0] pe, logic [7:0] se, logic et, logic [7:0] es);
        vec_t v;
        v.pc_f = pf; v.pred_f = p; v.br = b; v.act = a; v.misp = m;
        v.pc_e = pe; v.snap_e = se; v.exp_taken = et; v.exp_snap = es;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic idle();
        pc_idxF = '0; predF = 0; BranchE = 0; br_actualE = 0;
        mispredE = 0; pc_idxE = '0; ghr_snapE = '0;
    endtask

    // Called one time unit after a rising edge; leaves the bench at the same phase.
    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_init(input bit use_b, input int exp_cycles, input string name);
        int cnt;
        bit done;
        cnt  = 0;
        done = use_b ? b_done : a_done;
        while (!done && cnt < 4000) begin
            @(posedge clk);
            #1;
            cnt++;
            done = use_b ? b_done : a_done;
        end
        check(name, cnt, exp_cycles);
    endtask

    task automatic apply(input vec_t v, input bit use_b, input string tag);
        pc_idxF = v.pc_f; predF = v.pred_f; BranchE = v.br; br_actualE = v.act;
        mispredE = v.misp; pc_idxE = v.pc_e; ghr_snapE = v.snap_e;
        @(negedge clk);
        if (use_b) begin
            check({tag, ".taken"}, int'(b_taken), int'(v.exp_taken));
            check({tag, ".snap"}, int'({2'b00, b_snap}), int'(v.exp_snap));
        end else begin
            check({tag, ".taken"}, int'(a_taken), int'(v.exp_taken));
            check({tag, ".snap"}, int'(a_snap), int'(v.exp_snap));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ntaken;

        // Default instance: all counters 01, GHR 0 after the sweep.
        // Saturation at 0x155 (GHR held at 0).
        va.push_back(mk(10'h155, 0, 1, 1, 0, 10'h155, 8'h00, 0, 8'h00));
        va.push_back(mk(10'h155, 0, 1, 1, 0, 10'h155, 8'h00, 1, 8'h00));
        va.push_back(mk(10'h155, 0, 1, 1, 0, 10'h155, 8'h00, 1, 8'h00));
        va.push_back(mk(10'h155, 0, 1, 0, 0, 10'h155, 8'h00, 1, 8'h00));
        va.push_back(mk(10'h155, 0, 1, 0, 0, 10'h155, 8'h00, 1, 8'h00));
        va.push_back(mk(10'h155, 0, 1, 0, 0, 10'h155, 8'h00, 0, 8'h00));
        va.push_back(mk(10'h155, 0, 1, 0, 0, 10'h155, 8'h00, 0, 8'h00));
        va.push_back(mk(10'h155, 0, 0, 0, 0, 10'h000, 8'h00, 0, 8'h00));
        // Train 0x100 to 11, 0x202 and 0x0F5 to 10.
        va.push_back(mk(10'h3FF, 0, 1, 1, 0, 10'h100, 8'h00, 0, 8'h00));
        va.push_back(mk(10'h3FF, 0, 1, 1, 0, 10'h100, 8'h00, 0, 8'h00));
        va.push_back(mk(10'h3FF, 0, 1, 1, 0, 10'h202, 8'h00, 0, 8'h00));
        va.push_back(mk(10'h3FF, 0, 1, 1, 0, 10'h0F5, 8'h00, 0, 8'h00));
        // Speculative history: predictions 1,0,1 shift GHR 00 -> 01 -> 02 -> 05.
        va.push_back(mk(10'h100, 1, 0, 0, 0, 10'h000, 8'h00, 1, 8'h00));
        va.push_back(mk(10'h301, 1, 0, 0, 0, 10'h000, 8'h00, 0, 8'h01));
        va.push_back(mk(10'h200, 1, 0, 0, 0, 10'h000, 8'h00, 1, 8'h02));
        va.push_back(mk(10'h0F0, 0, 0, 0, 0, 10'h000, 8'h00, 1, 8'h05));
        // Recovery loads GHR = {0x52[6:0],1} = 0xA5.
        va.push_back(mk(10'h3FF, 0, 1, 1, 1, 10'h000, 8'h52, 0, 8'h05));
        // Recovery beats same-cycle predF: GHR = {0x3C[6:0],0} = 0x78.
        va.push_back(mk(10'h3FF, 1, 1, 0, 1, 10'h000, 8'h3C, 0, 8'hA5));
        // Correctly predicted branch leaves GHR alone.
        va.push_back(mk(10'h3FF, 0, 1, 1, 0, 10'h000, 8'h00, 0, 8'h78));
        // Collision at 0x088 (0x0F0 ^ 0x78): old value now, new value next cycle.
        va.push_back(mk(10'h0F0, 0, 1, 1, 0, 10'h088, 8'h00, 0, 8'h78));
        va.push_back(mk(10'h0F0, 0, 0, 0, 0, 10'h000, 8'h00, 1, 8'h78));

        // Small instance: 3-bit counters start at 3, 6-bit history.
        for (int i = 0; i < 5; i++)
            vb.push_back(mk(10'h15, 0, 1, 1, 0, 10'h15, 8'h00, (i != 0), 8'h00));
        for (int i = 0; i < 8; i++)
            vb.push_back(mk(10'h15, 0, 1, 0, 0, 10'h15, 8'h00, (i < 4), 8'h00));
        vb.push_back(mk(10'h15, 0, 0, 0, 0, 10'h00, 8'h00, 0, 8'h00));
        vb.push_back(mk(10'h3F, 0, 1, 1, 0, 10'h20, 8'h00, 0, 8'h00));
        vb.push_back(mk(10'h3F, 0, 1, 1, 0, 10'h22, 8'h00, 0, 8'h00));
        vb.push_back(mk(10'h20, 1, 0, 0, 0, 10'h00, 8'h00, 1, 8'h00));
        vb.push_back(mk(10'h31, 1, 0, 0, 0, 10'h00, 8'h00, 0, 8'h01));
        vb.push_back(mk(10'h20, 1, 0, 0, 0, 10'h00, 8'h00, 1, 8'h02));
        vb.push_back(mk(10'h3F, 1, 1, 0, 1, 10'h00, 8'h3C, 0, 8'h05));
        vb.push_back(mk(10'h3F, 0, 0, 0, 0, 10'h00, 8'h00, 0, 8'h38));
        vb.push_back(mk(10'h3F, 0, 1, 1, 0, 10'h07, 8'h38, 0, 8'h38));
        vb.push_back(mk(10'h07, 0, 0, 0, 0, 10'h00, 8'h00, 1, 8'h38));

        // Init sweep with EX/IF traffic that must be ignored.
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset.init_done", int'(a_done), 0);
        check("reset.taken", int'(a_taken), 0);
        check("reset.snap", int'(a_snap), 0);
        pc_idxF = 10'h155; predF = 1; BranchE = 1; br_actualE = 1;
        mispredE = 1; pc_idxE = 10'h155; ghr_snapE = 8'hFF;
        wait_init(1'b0, 1024, "init.cycles");
        idle();
        #1;
        check("init.ghr_untouched", int'(a_snap), 0);
        ntaken = 0;
        for (int i = 0; i < 1024; i++) begin
            pc_idxF = 10'(i);
            #1;
            if (a_taken) ntaken++;
        end
        check("init.all_not_taken", ntaken, 0);
        pc_idxF = '0;
        @(posedge clk);
        #1;

        foreach (va[i]) apply(va[i], 1'b0, $sformatf("A%0d", i));
        idle();

        // Mid-sweep reset: sweep restarts and takes the full length again.
        pulse_reset();
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
        end
        check("midsweep.not_done", int'(a_done), 0);
        pulse_reset();
        check("midsweep.reset_done", int'(a_done), 0);
        wait_init(1'b0, 1024, "midsweep.cycles");
        pc_idxF = 10'h100;
        @(negedge clk);
        check("midsweep.reswept", int'(a_taken), 0);
        check("midsweep.done_held", int'(a_done), 1);
        @(posedge clk);
        #1;

        // Small parameter set.
        idle();
        pulse_reset();
        check("B.reset_done", int'(b_done), 0);
        wait_init(1'b1, 64, "B.init.cycles");
        foreach (vb[i]) apply(vb[i], 1'b1, $sformatf("B%0d", i));
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
